alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (SHALL be >= 8, even).
REQ-002 Parameter SHAMT_W, default 5, shift-amount bits taken from regB[SHAMT_W-1:0] (SHALL equal log2(WIDTH)).
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand/op presented.
REQ-006 in_ready  out  1  block accepts; transfer when in_valid && in_ready.
REQ-007 regA, regB  in  WIDTH each  source operands.
REQ-008 alu_control  in  4  operation select.
REQ-009 out_valid  out  1  result held valid.
REQ-010 out_ready  in  1  consumer accepts; retire when out_valid && out_ready.
REQ-011 result  out  WIDTH  registered result.
REQ-012 zero  out  1  result == 0.
REQ-013 overflow  out  1  signed overflow for ADD/SUB, else 0.
REQ-014 dbz  out  1  divide/remainder by zero, else 0.

Function
REQ-015 Encodings SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits, unsigned), 1101 MULHU (high WIDTH bits), 1110 DIVU, 1111 REMU; 1011 SHALL behave as ADD.
REQ-016 FSM states SHALL be IDLE, MUL, DIV, HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE, or in HOLD when out_ready is 1 (back-to-back accept on retire).
REQ-018 Single-cycle ops accepted on edge N SHALL present out_valid=1 with result after edge N (state HOLD).
REQ-019 MUL/MULHU SHALL run shift-add, one bit per cycle: out_valid after edge N+WIDTH.
REQ-020 DIVU/REMU SHALL run restoring division, one bit per cycle: out_valid after edge N+WIDTH.
REQ-021 DIVU/REMU with regB==0 SHALL skip DIV: result all-ones (DIVU) or regA (REMU), dbz=1, out_valid after edge N.
REQ-022 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-023 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = operand signs equal (ADD) / differ (SUB) and result sign differs from regA.
REQ-024 result, zero, overflow, dbz SHALL stay stable while out_valid && !out_ready.
REQ-025 On retire without a new accept, state SHALL return to IDLE and out_valid drop to 0 next cycle; result keeps last value.
REQ-026 Inputs changing while not accepted SHALL have no effect; operands SHALL be latched on accept.

Reset
REQ-027 reset SHALL force IDLE, out_valid=0, result=0, zero=1, overflow=0, dbz=0, in_ready=1 at the next edge, aborting any MUL/DIV in progress with no output produced.

Configuration
REQ-028 Macro ALU_MDU_DIV_EN SHALL compile in the divider; when defined, REQ-020/021 apply.
REQ-029 Without ALU_MDU_DIV_EN, DIVU/REMU SHALL complete single-cycle with result=0, dbz=1, and DIV state SHALL not exist.

Structure
REQ-030 Package alu_pkg SHALL hold the 4-bit op encodings as named constants and the FSM state typedef.
REQ-031 Iterative multiply/divide datapath SHALL be sub-module alu_mdu_iter (start, op, operands in; done, product/quotient/remainder out); alu_mdu holds the handshake FSM and single-cycle ops.

Verification
REQ-032 ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> result 0x80000000, overflow=1, out_valid one cycle after accept.
REQ-033 SUB 5-5 -> result 0, zero=1; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-034 MUL 0x00010000 x 0x00010000 -> MUL 0, MULHU 0x00000001, out_valid exactly 32 cycles after accept, in_ready=0 meanwhile.
REQ-035 DIVU 100/7 -> 14, REMU -> 2, latency 32; DIVU 9/0 -> 0xFFFFFFFF, dbz=1, latency 1 (without macro: 0, dbz=1).
REQ-036 out_ready held 0 for 5 cycles after result -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept same edge.
REQ-037 reset asserted at cycle 10 of a MUL -> next cycle IDLE, out_valid=0, result=0; no stale result later.

Source files
------------

// File: rtl/alu_pkg.sv
//-----------------------------------------------------------------------------
// alu_pkg : op encodings and handshake FSM state type for alu_mdu
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_OR      = 4'b0001;
   localparam logic [3:0] OP_ADD     = 4'b0010;
   localparam logic [3:0] OP_XOR     = 4'b0011;
   localparam logic [3:0] OP_NOR     = 4'b0100;
   localparam logic [3:0] OP_SLTU    = 4'b0101;
   localparam logic [3:0] OP_SUB     = 4'b0110;
   localparam logic [3:0] OP_SLT     = 4'b0111;
   localparam logic [3:0] OP_SLL     = 4'b1000;
   localparam logic [3:0] OP_SRL     = 4'b1001;
   localparam logic [3:0] OP_SRA     = 4'b1010;
   localparam logic [3:0] OP_ADD_ALT = 4'b1011;
   localparam logic [3:0] OP_MUL     = 4'b1100;
   localparam logic [3:0] OP_MULHU   = 4'b1101;
   localparam logic [3:0] OP_DIVU    = 4'b1110;
   localparam logic [3:0] OP_REMU    = 4'b1111;

`ifdef ALU_MDU_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, HOLD = 2'd3} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd3} state_e;
`endif

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mdu_iter.sv
//-----------------------------------------------------------------------------
// alu_mdu_iter : bit-serial shift-add multiplier / restoring divider
// Build option: ALU_MDU_DIV_EN compiles in the divider.  Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module alu_mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder
);

   // hi/lo are shared: {acc, multiplier} for MUL, {remainder, dividend/quotient} for DIV
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             start_eff;

   function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] m);
      logic [WIDTH:0] s;
      s = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      return {s[WIDTH:1], s[0], lo[WIDTH-1:1]};
   endfunction

`ifdef ALU_MDU_DIV_EN
   logic is_div_q, is_div_d;

   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH:0] sh;
      logic [WIDTH:0] df;
      sh = {rem, q[WIDTH-1]};
      df = sh - {1'b0, d};
      return {(df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0]), q[WIDTH-2:0], ~df[WIDTH]};
   endfunction

   assign start_eff = start;
`else
   assign start_eff = start && !is_div_op(op);
`endif

   // The first step is folded into the start cycle so WIDTH steps finish WIDTH edges after start
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div_d = is_div_q;
`endif
      if (start_eff) begin
         m_d    = b;
         cnt_d  = CNT_W'(1);
         busy_d = 1'b1;
`ifdef ALU_MDU_DIV_EN
         is_div_d = is_div_op(op);
         {hi_d, lo_d} = is_div_op(op) ? div_step('0, a, b) : mul_step('0, a, b);
`else
         {hi_d, lo_d} = mul_step('0, a, b);
`endif
      end else if (busy_q) begin
`ifdef ALU_MDU_DIV_EN
         {hi_d, lo_d} = is_div_q ? div_step(hi_q, lo_q, m_q) : mul_step(hi_q, lo_q, m_q);
`else
         {hi_d, lo_d} = mul_step(hi_q, lo_q, m_q);
`endif
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         m_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef ALU_MDU_DIV_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   assign done      = done_q;
   assign product   = {hi_q, lo_q};
   assign quotient  = lo_q;
   assign remainder = hi_q;

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
//-----------------------------------------------------------------------------
// alu_mdu : valid/ready ALU with iterative MUL and optional DIV
// Build option: ALU_MDU_DIV_EN compiles in the divider.  Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] regA,
   input  logic [WIDTH-1:0] regB,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             dbz
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, overflow_q, overflow_d, dbz_q, dbz_d;
   logic [3:0]       op_q, op_d;

   logic               accept, iter_start, iter_done;
   logic [2*WIDTH-1:0] iter_product;
   logic [WIDTH-1:0]   iter_quotient, iter_remainder, iter_res;
   logic [WIDTH-1:0]   alu_res, sum, diff;
   logic               alu_ovf;
   logic [SHAMT_W-1:0] shamt;

   assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign sum       = regA + regB;
   assign diff      = regA - regB;
   assign shamt     = regB[SHAMT_W-1:0];

   always_comb begin
      alu_res = sum;
      alu_ovf = 1'b0;
      case (alu_control)
         OP_AND:  alu_res = regA & regB;
         OP_OR:   alu_res = regA | regB;
         OP_XOR:  alu_res = regA ^ regB;
         OP_NOR:  alu_res = ~(regA | regB);
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (regA < regB)};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(regA) < $signed(regB))};
         OP_SLL:  alu_res = regA << shamt;
         OP_SRL:  alu_res = regA >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(regA) >>> shamt);
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (regA[WIDTH-1] != regB[WIDTH-1]) && (diff[WIDTH-1] != regA[WIDTH-1]);
         end
         default: alu_ovf = (regA[WIDTH-1] == regB[WIDTH-1]) && (sum[WIDTH-1] != regA[WIDTH-1]);
      endcase
   end

   always_comb begin
      case (op_q)
         OP_MULHU: iter_res = iter_product[2*WIDTH-1:WIDTH];
         OP_DIVU:  iter_res = iter_quotient;
         OP_REMU:  iter_res = iter_remainder;
         default:  iter_res = iter_product[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;
      op_d       = op_q;
      iter_start = 1'b0;
      case (state_q)
         IDLE: ;
`ifdef ALU_MDU_DIV_EN
         MUL, DIV: begin
`else
         MUL: begin
`endif
            if (iter_done) begin
               state_d    = HOLD;
               result_d   = iter_res;
               overflow_d = 1'b0;
               dbz_d      = 1'b0;
            end
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An accept in HOLD overrides the retire-to-IDLE above (back-to-back)
      if (accept) begin
         op_d = alu_control;
         if ((alu_control == OP_MUL) || (alu_control == OP_MULHU)) begin
            state_d    = MUL;
            iter_start = 1'b1;
         end else if (is_div_op(alu_control)) begin
`ifdef ALU_MDU_DIV_EN
            if (regB == '0) begin
               state_d    = HOLD;
               result_d   = (alu_control == OP_DIVU) ? '1 : regA;
               overflow_d = 1'b0;
               dbz_d      = 1'b1;
            end else begin
               state_d    = DIV;
               iter_start = 1'b1;
            end
`else
            state_d    = HOLD;
            result_d   = '0;
            overflow_d = 1'b0;
            dbz_d      = 1'b1;
`endif
         end else begin
            state_d    = HOLD;
            result_d   = alu_res;
            overflow_d = alu_ovf;
            dbz_d      = 1'b0;
         end
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b1;
         overflow_q <= 1'b0;
         dbz_q      <= 1'b0;
         op_q       <= OP_AND;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         dbz_q      <= dbz_d;
         op_q       <= op_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign dbz      = dbz_q;

   alu_mdu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (SHAMT_W)
   ) u_iter (
      .clock     (clock),
      .reset     (reset),
      .start     (iter_start),
      .op        (alu_control),
      .a         (regA),
      .b         (regB),
      .done      (iter_done),
      .product   (iter_product),
      .quotient  (iter_quotient),
      .remainder (iter_remainder)
   );

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
//-----------------------------------------------------------------------------
// tb_alu_mdu : directed self-checking bench for alu_mdu (WIDTH=32)
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_alu_mdu;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] regA, regB, result;
   logic [3:0]  alu_control;
   logic        zero, overflow, dbz;

   int checks = 0;
   int errors = 0;
   logic ready_seen;

   alu_mdu dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .regA        (regA),
      .regB        (regB),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .dbz         (dbz)
   );

   always #5 clock = ~clock;

   // Presents one op, then scrambles the inputs and counts edges after accept until out_valid
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
      alu_control = op;
      regA        = a;
      regB        = b;
      in_valid    = 1'b1;
      @(posedge clock); #1;
      in_valid    = 1'b0;
      regA        = 32'hDEAD_BEEF;
      regB        = 32'h0;
      alu_control = OP_SUB;
      edges       = 0;
      ready_seen  = 1'b0;
      while (!out_valid && edges < 100) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clock); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      regA = '0; regB = '0; alu_control = OP_AND;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checks++;
      if ({out_valid, in_ready, zero, overflow, dbz} !== 5'b01100) begin
         errors++;
         $display("FAIL reset_flags: got v/r/z/o/d=%b expected 01100",
                  {out_valid, in_ready, zero, overflow, dbz});
      end
      checks++;
      if (result !== 32'h0) begin
         errors++; $display("FAIL reset_result: got %h expected 00000000", result);
      end
   endtask

   task automatic test_add_overflow();
      int edges;
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, edges);
      checks++;
      if (edges !== 0) begin
         errors++; $display("FAIL add_latency: got %0d expected 0", edges);
      end
      checks++;
      if ({result, overflow, zero, dbz} !== {32'h8000_0000, 3'b100}) begin
         errors++;
         $display("FAIL add_ovf: got %h o=%b z=%b d=%b expected 80000000 o=1 z=0 d=0",
                  result, overflow, zero, dbz);
      end
      @(posedge clock); #1;
      checks++;
      if ({out_valid, result} !== {1'b0, 32'h8000_0000}) begin
         errors++;
         $display("FAIL add_retire: got v=%b res=%h expected v=0 res=80000000", out_valid, result);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, r;
      logic        ov;
   } vec_t;

   task automatic test_single_cycle();
      vec_t v[13];
      int   edges;
      v[0]  = '{OP_SUB,     32'd5,         32'd5,         32'd0,         1'b0};
      v[1]  = '{OP_SLT,     32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
      v[2]  = '{OP_SLTU,    32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      v[3]  = '{OP_SRA,     32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
      v[4]  = '{OP_SRL,     32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
      v[5]  = '{OP_SLL,     32'd1,         32'h0000_0023, 32'd8,         1'b0};
      v[6]  = '{OP_AND,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
      v[7]  = '{OP_OR,      32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
      v[8]  = '{OP_XOR,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
      v[9]  = '{OP_NOR,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0};
      v[10] = '{OP_SUB,     32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
      v[11] = '{OP_ADD_ALT, 32'd2,         32'd3,         32'd5,         1'b0};
      v[12] = '{OP_ADD,     32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      for (int i = 0; i < 13; i++) begin
         issue(v[i].op, v[i].a, v[i].b, edges);
         checks++;
         if ({edges[7:0], result, overflow, zero, dbz} !==
             {8'd0, v[i].r, v[i].ov, (v[i].r == 32'd0), 1'b0}) begin
            errors++;
            $display("FAIL single_%0d op=%b: got lat=%0d res=%h o=%b z=%b d=%b expected lat=0 res=%h o=%b z=%b d=0",
                     i, v[i].op, edges, result, overflow, zero, dbz, v[i].r, v[i].ov, (v[i].r == 32'd0));
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_mul();
      logic [3:0]  ops [4] = '{OP_MUL, OP_MULHU, OP_MUL, OP_MULHU};
      logic [31:0] as  [4] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'hFFFF_FFFF};
      logic [31:0] bs  [4] = '{32'h0001_0000, 32'h0001_0000, 32'd6, 32'hFFFF_FFFF};
      logic [31:0] rs  [4] = '{32'h0, 32'h1, 32'd42, 32'hFFFF_FFFE};
      int edges;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i], edges);
         checks++;
         if (edges !== 32) begin
            errors++; $display("FAIL mul_%0d_latency: got %0d expected 32", i, edges);
         end
         checks++;
         if (ready_seen !== 1'b0) begin
            errors++; $display("FAIL mul_%0d_in_ready: got in_ready=1 while busy expected 0", i);
         end
         checks++;
         if ({result, zero, overflow, dbz} !== {rs[i], (rs[i] == 32'd0), 2'b00}) begin
            errors++;
            $display("FAIL mul_%0d_result: got %h z=%b o=%b d=%b expected %h", i, result, zero,
                     overflow, dbz, rs[i]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_div();
`ifdef ALU_MDU_DIV_EN
      logic [3:0]  ops [5] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU};
      logic [31:0] as  [5] = '{32'd100, 32'd100, 32'd9, 32'd9, 32'hFFFF_FFFF};
      logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1};
      logic [31:0] rs  [5] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF};
      logic        ds  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int          ls  [5] = '{32, 32, 0, 0, 32};
`else
      logic [3:0]  ops [5] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU};
      logic [31:0] as  [5] = '{32'd100, 32'd100, 32'd9, 32'd9, 32'hFFFF_FFFF};
      logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1};
      logic [31:0] rs  [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      logic        ds  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int          ls  [5] = '{0, 0, 0, 0, 0};
`endif
      int edges;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i], edges);
         checks++;
         if (edges !== ls[i]) begin
            errors++; $display("FAIL div_%0d_latency: got %0d expected %0d", i, edges, ls[i]);
         end
         checks++;
         if ({result, dbz, overflow} !== {rs[i], ds[i], 1'b0}) begin
            errors++;
            $display("FAIL div_%0d_result: got %h d=%b o=%b expected %h d=%b o=0", i, result, dbz,
                     overflow, rs[i], ds[i]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      out_ready = 1'b0;
      issue(OP_ADD, 32'd10, 32'd20, edges);
      in_valid = 1'b1; alu_control = OP_SUB; regA = 32'd100; regB = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if ({out_valid, in_ready, result, zero} !== {2'b10, 32'd30, 1'b0}) begin
            errors++;
            $display("FAIL stall_%0d: got v=%b r=%b res=%h z=%b expected v=1 r=0 res=0000001e z=0",
                     i, out_valid, in_ready, result, zero);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result} !== {1'b1, 32'd99}) begin
         errors++; $display("FAIL b2b_result: got v=%b res=%h expected v=1 res=00000063", out_valid, result);
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_retire: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic stale;
      alu_control = OP_MUL; regA = 32'd3; regB = 32'd5; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++;
      if ({out_valid, in_ready, zero, result} !== {3'b011, 32'd0}) begin
         errors++;
         $display("FAIL midreset_state: got v=%b r=%b z=%b res=%h expected v=0 r=1 z=1 res=00000000",
                  out_valid, in_ready, zero, result);
      end
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (out_valid || result !== 32'd0) stale = 1'b1;
      end
      checks++;
      if (stale !== 1'b0) begin
         errors++; $display("FAIL midreset_stale: got a late result expected none");
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_single_cycle();
      test_mul();
      test_div();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

`default_nettype wire
